// File: rtl/stereo_pkg.sv
// stereo_pkg: shared widths, FSM states and disparity type for the stereo search path.
package stereo_pkg;
    localparam int X_W    = 9;
    localparam int Y_W    = 10;
    localparam int SSD_W  = 23;
    localparam int DISP_N = 16;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;
    typedef logic [$clog2(DISP_N)-1:0] disparity_t;
endpackage

// File: rtl/disparity_search_ctrl_if.sv
// disparity_search_ctrl_if: job/result bus between the search controller and one SSD engine.
interface disparity_search_ctrl_if
    import stereo_pkg::*;
#(
    parameter int SSD_W = stereo_pkg::SSD_W
);
    logic             ssd_rst_out;
    logic             ssd_valid_out;
    logic [X_W-1:0]   ssd_left_x_out;
    logic [X_W-1:0]   ssd_right_x_out;
    logic [Y_W-1:0]   ssd_y_out;
    logic [X_W-1:0]   ssd_block_idx_out;
    logic             ssd_valid_in;
    logic [SSD_W-1:0] ssd_in;
    modport master (
        output ssd_rst_out, ssd_valid_out, ssd_left_x_out, ssd_right_x_out, ssd_y_out, ssd_block_idx_out,
        input  ssd_valid_in, ssd_in
    );
    modport slave (
        input  ssd_rst_out, ssd_valid_out, ssd_left_x_out, ssd_right_x_out, ssd_y_out, ssd_block_idx_out,
        output ssd_valid_in, ssd_in
    );
endinterface

// File: rtl/disparity_search_ctrl_min_tracker.sv
// min_tracker: compare-and-hold of the smallest value seen and its index; strict-less update
// so a tie keeps the earlier index. Outputs show the value that will be held after this cycle.
module min_tracker #(
    parameter int VAL_W = 23,
    parameter int IDX_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_init,
    input  logic             i_en,
    input  logic [VAL_W-1:0] i_val,
    input  logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] o_best,
    output logic [VAL_W-1:0] o_min
);
    logic [IDX_W-1:0] r_best;
    logic [VAL_W-1:0] r_min;
    logic             w_take;

    assign w_take = i_en && (i_val < r_min);
    assign o_best = w_take ? i_idx : r_best;
    assign o_min  = w_take ? i_val : r_min;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_best <= '0;
            r_min  <= '0;
        end else if (i_init) begin
            r_best <= '0;
            r_min  <= '1;
        end else begin
            r_best <= o_best;
            r_min  <= o_min;
        end
    end
endmodule

// File: rtl/disparity_search_ctrl.sv
// disparity_search_ctrl: sweeps candidate disparities for one left block through a single
// SSD engine (one job in flight) and reports the disparity with the minimum SSD.
module disparity_search_ctrl
    import stereo_pkg::*;
#(
    parameter int MAX_DISP  = stereo_pkg::DISP_N,
    parameter int IMG_WIDTH = 240,
    parameter int BLOCK     = 6,
    parameter int SSD_W     = stereo_pkg::SSD_W,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [X_W-1:0]              left_x_in,
    input  logic [Y_W-1:0]              y_in,
    input  logic [X_W-1:0]              block_idx_in,
    disparity_search_ctrl_if.master     bus,
    output logic                        busy_out,
    output logic                        valid_out,
    output logic [$clog2(MAX_DISP)-1:0] disparity_out,
    output logic [SSD_W-1:0]            min_ssd_out,
    output logic                        error_out
);
    localparam int DW = $clog2(MAX_DISP);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t           r_state, w_next;
    logic [X_W-1:0]   r_left_x, r_right_x, r_blk;
    logic [Y_W-1:0]   r_y;
    logic [DW-1:0]    r_d;
    logic [CW-1:0]    r_cnt;
    logic [SSD_W-1:0] r_ssd, r_min_out;
    logic [DW-1:0]    r_disp;
    logic             r_err;
    logic             w_accept, w_to, w_last;
    logic [DW:0]      w_d_inc;
    logic [DW-1:0]    w_best;
    logic [SSD_W-1:0] w_min;

    assign w_accept = (r_state == S_IDLE) && start_in;
    assign w_to     = r_cnt == TO_LAST;
    assign w_d_inc  = {1'b0, r_d} + 1'b1;
    // Edge bound evaluated at 10 bits so left_x + d + BLOCK cannot wrap.
    assign w_last   = (w_d_inc == (DW+1)'(MAX_DISP)) ||
                      ((10'(r_left_x) + 10'(w_d_inc) + 10'(BLOCK)) > 10'(IMG_WIDTH));

    min_tracker #(.VAL_W(SSD_W), .IDX_W(DW)) u_min (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_init (w_accept),
        .i_en   (r_state == S_NEXT),
        .i_val  (r_ssd),
        .i_idx  (r_d),
        .o_best (w_best),
        .o_min  (w_min)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start_in ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = bus.ssd_valid_in ? S_NEXT : (w_to ? S_DONE : S_WAIT);
            S_NEXT:  w_next = w_last ? S_DONE : S_CLEAR;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_left_x  <= '0;
            r_right_x <= '0;
            r_blk     <= '0;
            r_y       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_ssd     <= '0;
            r_err     <= 1'b0;
            r_disp    <= '0;
            r_min_out <= '0;
        end else begin
            if (w_accept) begin
                r_left_x  <= left_x_in;
                r_right_x <= left_x_in;
                r_y       <= y_in;
                r_blk     <= block_idx_in;
                r_d       <= '0;
                r_err     <= 1'b0;
            end
            if (r_state == S_ISSUE) r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_WAIT && bus.ssd_valid_in) r_ssd <= bus.ssd_in;
            if (r_state == S_WAIT && !bus.ssd_valid_in && w_to) r_err <= 1'b1;
            if (r_state == S_NEXT) begin
                r_d       <= w_d_inc[DW-1:0];
                r_right_x <= r_left_x + X_W'(w_d_inc);
            end
            // Results land on entry to DONE so they are visible with valid_out.
            if (w_next == S_DONE) begin
                r_disp    <= w_best;
                r_min_out <= w_min;
            end
        end
    end

    assign bus.ssd_rst_out       = r_state == S_CLEAR;
    assign bus.ssd_valid_out     = r_state == S_ISSUE;
    assign bus.ssd_left_x_out    = r_left_x;
    assign bus.ssd_right_x_out   = r_right_x;
    assign bus.ssd_y_out         = r_y;
    assign bus.ssd_block_idx_out = r_blk;
    assign busy_out      = r_state != S_IDLE;
    assign valid_out     = r_state == S_DONE;
    assign disparity_out = r_disp;
    assign min_ssd_out   = r_min_out;
    assign error_out     = r_err;
endmodule

// File: tb/tb_disparity_search_ctrl.sv
// tb_disparity_search_ctrl: directed checks of the disparity search controller against a
// behavioural SSD engine with fixed latency L=4.
module tb_disparity_search_ctrl;
    import stereo_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  lx = '0;
    logic [9:0]  y = '0;
    logic [8:0]  bi = '0;
    logic        busy, vld, err;
    logic [3:0]  disp;
    logic [22:0] mssd;

    int vectors = 0;
    int errors = 0;
    int mode = 0;
    int stall_d = -1;
    int jobs = 0;
    int spur_req = 0;
    int spur_done = 0;
    int md;
    int rx_log[$];
    int lx_log[$];

    disparity_search_ctrl_if bus();

    disparity_search_ctrl dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start),
        .left_x_in     (lx),
        .y_in          (y),
        .block_idx_in  (bi),
        .bus           (bus),
        .busy_out      (busy),
        .valid_out     (vld),
        .disparity_out (disp),
        .min_ssd_out   (mssd),
        .error_out     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] ssd_of(input int d);
        case (mode)
            0:       return 23'((d > 5 ? d - 5 : 5 - d) * 1000);
            1:       return 23'((d == 2 || d == 7) ? 500 : 1000 + d * 10);
            2:       return 23'(900 - 100 * d);
            default: return 23'(100 + d);
        endcase
    endfunction

    // SSD engine: answers L cycles after the job strobe unless the candidate is set to stall.
    initial begin
        bus.ssd_valid_in = 1'b0;
        bus.ssd_in = '0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                bus.ssd_in = 23'd3;
                bus.ssd_valid_in = 1'b1;
                @(negedge clk);
                bus.ssd_valid_in = 1'b0;
                spur_done = spur_req;
            end else if (bus.ssd_valid_out) begin
                md = int'(bus.ssd_right_x_out) - int'(bus.ssd_left_x_out);
                jobs++;
                rx_log.push_back(int'(bus.ssd_right_x_out));
                lx_log.push_back(int'(bus.ssd_left_x_out));
                if (md != stall_d) begin
                    repeat (L) @(negedge clk);
                    bus.ssd_in = ssd_of(md);
                    bus.ssd_valid_in = 1'b1;
                    @(negedge clk);
                    bus.ssd_valid_in = 1'b0;
                end
            end
        end
    end

    // Starts a search and counts rising edges after the start edge until valid_out.
    task automatic run(input logic [8:0] x, input int poke, output int edges);
        @(negedge clk);
        jobs = 0;
        rx_log.delete();
        lx_log.delete();
        lx = x;
        y = 10'd77;
        bi = 9'd33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (!vld && edges < 3000) begin
            @(negedge clk);
            edges++;
            start = (edges == poke);
            if (edges == poke) lx = 9'd50;
        end
        start = 1'b0;
        vectors++;
        if (!vld) begin
            errors++;
            $display("FAIL run_done: valid_out=%0b after %0d edges, required 1", vld, edges);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, vld, err, disp, mssd, bus.ssd_rst_out, bus.ssd_valid_out} !== '0 ||
            {bus.ssd_left_x_out, bus.ssd_right_x_out, bus.ssd_y_out, bus.ssd_block_idx_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b vld=%0b err=%0b disp=%0d min=%0d, required all 0",
                     busy, vld, err, disp, mssd);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int e, bad;
        mode = 0;
        stall_d = -1;
        run(9'd0, -1, e);
        vectors++;
        if (e !== 16 * (3 + L)) begin
            errors++;
            $display("FAIL basic_latency: edges=%0d, required %0d", e, 16 * (3 + L));
        end
        vectors++;
        if (disp !== 4'd5 || mssd !== 23'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: disp=%0d min=%0d err=%0b, required 5 0 0", disp, mssd, err);
        end
        bad = 0;
        foreach (rx_log[i]) if (rx_log[i] != i) bad++;
        vectors++;
        if (jobs !== 16 || bad !== 0) begin
            errors++;
            $display("FAIL basic_jobs: jobs=%0d bad_right_x=%0d, required 16 0", jobs, bad);
        end
        vectors++;
        if (bus.ssd_y_out !== 10'd77 || bus.ssd_block_idx_out !== 9'd33) begin
            errors++;
            $display("FAIL basic_coords: y=%0d blk=%0d, required 77 33", bus.ssd_y_out, bus.ssd_block_idx_out);
        end
        @(negedge clk);
        vectors++;
        if (vld !== 1'b0 || busy !== 1'b0 || disp !== 4'd5 || mssd !== 23'd0) begin
            errors++;
            $display("FAIL basic_hold: vld=%0b busy=%0b disp=%0d min=%0d, required 0 0 5 0", vld, busy, disp, mssd);
        end
    endtask

    task automatic test_tie();
        int e;
        mode = 1;
        run(9'd0, -1, e);
        vectors++;
        if (disp !== 4'd2 || mssd !== 23'd500) begin
            errors++;
            $display("FAIL tie_result: disp=%0d min=%0d, required 2 500", disp, mssd);
        end
    endtask

    task automatic test_right_edge();
        int e;
        mode = 3;
        run(9'd228, -1, e);
        vectors++;
        if (jobs !== 7 || rx_log[rx_log.size() - 1] !== 234 || e !== 7 * (3 + L)) begin
            errors++;
            $display("FAIL edge_jobs: jobs=%0d last_rx=%0d edges=%0d, required 7 234 %0d",
                     jobs, rx_log[rx_log.size() - 1], e, 7 * (3 + L));
        end
        vectors++;
        if (disp !== 4'd0 || mssd !== 23'd100) begin
            errors++;
            $display("FAIL edge_result: disp=%0d min=%0d, required 0 100", disp, mssd);
        end
    endtask

    task automatic test_boundary_d0();
        int e;
        mode = 3;
        run(9'd239, -1, e);
        vectors++;
        if (jobs !== 1 || e !== 3 + L || mssd !== 23'd100) begin
            errors++;
            $display("FAIL d0_only: jobs=%0d edges=%0d min=%0d, required 1 %0d 100", jobs, e, 3 + L, mssd);
        end
    endtask

    task automatic test_timeout();
        int e;
        mode = 2;
        stall_d = 4;
        run(9'd0, -1, e);
        vectors++;
        if (e !== 4 * (3 + L) + 2 + 1024) begin
            errors++;
            $display("FAIL timeout_latency: edges=%0d, required %0d", e, 4 * (3 + L) + 2 + 1024);
        end
        vectors++;
        if (err !== 1'b1 || disp !== 4'd3 || mssd !== 23'd600 || jobs !== 5) begin
            errors++;
            $display("FAIL timeout_result: err=%0b disp=%0d min=%0d jobs=%0d, required 1 3 600 5", err, disp, mssd, jobs);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%0b, required 1", err);
        end
    endtask

    task automatic test_timeout_d0();
        int e;
        mode = 2;
        stall_d = 0;
        run(9'd0, -1, e);
        vectors++;
        if (err !== 1'b1 || disp !== 4'd0 || mssd !== 23'h7FFFFF || e !== 2 + 1024) begin
            errors++;
            $display("FAIL timeout_d0: err=%0b disp=%0d min=%0h edges=%0d, required 1 0 7fffff %0d",
                     err, disp, mssd, e, 2 + 1024);
        end
        stall_d = -1;
    endtask

    task automatic test_start_busy();
        int e, bad;
        mode = 0;
        run(9'd0, 20, e);
        bad = 0;
        foreach (lx_log[i]) if (lx_log[i] != 0) bad++;
        vectors++;
        if (bad !== 0 || jobs !== 16 || e !== 16 * (3 + L)) begin
            errors++;
            $display("FAIL busy_start: bad_left_x=%0d jobs=%0d edges=%0d, required 0 16 %0d", bad, jobs, e, 16 * (3 + L));
        end
        vectors++;
        if (disp !== 4'd5 || err !== 1'b0) begin
            errors++;
            $display("FAIL busy_result: disp=%0d err=%0b, required 5 0", disp, err);
        end
    endtask

    task automatic test_spurious();
        bit seen;
        seen = 1'b0;
        spur_req++;
        repeat (4) begin
            @(negedge clk);
            if (busy || vld) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || disp !== 4'd5 || mssd !== 23'd0) begin
            errors++;
            $display("FAIL spurious: activity=%0b disp=%0d min=%0d, required 0 5 0", seen, disp, mssd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        mode = 0;
        @(negedge clk);
        jobs = 0;
        lx = 9'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (jobs < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, vld, err, disp, mssd, bus.ssd_rst_out, bus.ssd_valid_out} !== '0 ||
            {bus.ssd_left_x_out, bus.ssd_right_x_out, bus.ssd_y_out, bus.ssd_block_idx_out} !== '0 || jobs !== 4) begin
            errors++;
            $display("FAIL reset_mid: busy=%0b disp=%0d min=%0d rx=%0d jobs=%0d, required all 0 with jobs 4",
                     busy, disp, mssd, bus.ssd_right_x_out, jobs);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vld || busy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_valid: activity after reset=%0b, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_right_edge();
        test_boundary_d0();
        test_timeout();
        test_timeout_d0();
        test_start_busy();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
